// File: rtl/uart_receiver.sv
// uart_receiver: 16x-oversampled UART receiver, 1 start bit, DATA_WIDTH data
// bits LSB-first, 1 stop bit, no parity.
// Ports:
//   clk        system clock
//   rstN       asynchronous active-low reset
//   baudTick   one-clk strobe at 16x the baud rate
//   rx         serial line, idle high, asynchronous to clk
//   dataOut    last correctly received word
//   RxDone     one-clk pulse, new word valid on dataOut
//   frameError one-clk pulse, stop bit sampled low
//   RxBusy     high while the receiver is not idle
module uart_receiver #(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rstN,
   input  logic                  baudTick,
   input  logic                  rx,
   output logic [DATA_WIDTH-1:0] dataOut,
   output logic                  RxDone,
   output logic                  frameError,
   output logic                  RxBusy
);

   localparam int unsigned TICK_W = 4;
   // a 1-bit word still needs a 1-bit counter
   localparam int unsigned BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] DATA  = 2'd2;
   localparam logic [1:0] STOP  = 2'd3;

   logic                  rxMeta;
   logic                  rxS;
   logic                  rxPrev;

   logic [1:0]            state,     stateNext;
   logic [TICK_W-1:0]     tickCnt,   tickNext;
   logic [BIT_W-1:0]      bitCnt,    bitNext;
   logic [DATA_WIDTH-1:0] shiftReg,  shiftNext;
   logic [DATA_WIDTH-1:0] dataNext;
   logic                  doneNext;
   logic                  errNext;

   // two-flop synchronizer plus one delayed copy for edge detection
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         rxMeta <= 1'b1;
         rxS    <= 1'b1;
         rxPrev <= 1'b1;
      end else begin
         rxMeta <= rx;
         rxS    <= rxMeta;
         rxPrev <= rxS;
      end
   end

   // state and datapath registers
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state      <= IDLE;
         tickCnt    <= '0;
         bitCnt     <= '0;
         shiftReg   <= '0;
         dataOut    <= '0;
         RxDone     <= 1'b0;
         frameError <= 1'b0;
      end else begin
         state      <= stateNext;
         tickCnt    <= tickNext;
         bitCnt     <= bitNext;
         shiftReg   <= shiftNext;
         dataOut    <= dataNext;
         RxDone     <= doneNext;
         frameError <= errNext;
      end
   end

   // next-state and datapath logic
   always_comb begin
      stateNext = state;
      tickNext  = tickCnt;
      bitNext   = bitCnt;
      shiftNext = shiftReg;
      dataNext  = dataOut;
      doneNext  = 1'b0;
      errNext   = 1'b0;

      case (state)
         IDLE: begin
            // edge required: a line held low never retriggers
            if (rxPrev && !rxS) begin
               stateNext = START;
               tickNext  = '0;
            end
         end

         START: begin
            if (baudTick) begin
               if (tickCnt == TICK_W'(7)) begin
                  // mid start bit: still low means a real frame
                  if (!rxS) begin
                     stateNext = DATA;
                     tickNext  = '0;
                     bitNext   = '0;
                  end else begin
                     stateNext = IDLE;
                  end
               end else begin
                  tickNext = tickCnt + TICK_W'(1);
               end
            end
         end

         DATA: begin
            if (baudTick) begin
               // wraps 15 -> 0, so each sample is 16 ticks after the last
               tickNext = tickCnt + TICK_W'(1);
               if (tickCnt == TICK_W'(15)) begin
                  shiftNext                 = shiftReg >> 1;
                  shiftNext[DATA_WIDTH-1]   = rxS;
                  if (bitCnt == BIT_W'(DATA_WIDTH - 1)) begin
                     stateNext = STOP;
                  end else begin
                     bitNext = bitCnt + BIT_W'(1);
                  end
               end
            end
         end

         STOP: begin
            if (baudTick) begin
               tickNext = tickCnt + TICK_W'(1);
               if (tickCnt == TICK_W'(15)) begin
                  stateNext = IDLE;
                  if (rxS) begin
                     dataNext = shiftReg;
                     doneNext = 1'b1;
                  end else begin
                     errNext  = 1'b1;
                  end
               end
            end
         end

         default: stateNext = IDLE;
      endcase
   end

   assign RxBusy = (state != IDLE);

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
UART serial receiver that samples `rx` at 16x oversampling using the shared `baudTick` strobe. Frame format: 1 start bit (0), DATA_WIDTH data bits LSB-first, 1 stop bit (1), no parity. It is the receive counterpart of the core's UART transmitter and presents each received word to the core/memory loader with a one-cycle done pulse. Framing errors are flagged.

Parameters:
DATA_WIDTH, 8, number of data bits per frame (1..16).

Ports:
clk  input  1  system clock
rstN  input  1  asynchronous active-low reset
baudTick  input  1  one-clk strobe at 16x baud rate
rx  input  1  serial line, idle high, asynchronous to clk
dataOut  output  DATA_WIDTH  last correctly received word
RxDone  output  1  one-clk pulse: new word valid on dataOut
frameError  output  1  one-clk pulse: stop bit sampled low
RxBusy  output  1  high while state != idle

Behaviour:
- Reset: rstN is asynchronous, active-low; clock is clk.
- Values while rstN is low:
  - dataOut=0, RxDone=0, frameError=0, RxBusy=0.
  - Tick counter=0, bit counter=0, shift register=0.
  - Synchronizer flops and previous-rx flop=1.
  - State=idle.
- Reset mid-frame aborts the frame; no RxDone/frameError is generated for it.
- Input sync: rx passes through 2 flops (rxS); rxPrev holds rxS delayed 1 clk. All decisions use rxS.
- Tick counter: 4-bit, advances only on clk edges where baudTick=1. Bit counter width is clog2(DATA_WIDTH).
- States:
  - idle: falling edge on rxS (rxPrev=1, rxS=0) -> start, tick=0. Evaluated every clk, independent of baudTick.
    - A line held low does not retrigger: an edge is required.
  - start: on baudTick, tick++. When tick==7 (mid start bit) with baudTick:
    - if rxS==0 -> data, tick=0, bitcount=0;
    - else (glitch/false start) -> idle, no pulses.
  - data: on baudTick, tick++. When tick==15 with baudTick:
    - shift register <= {rxS, shift[DATA_WIDTH-1:1]} (LSB-first);
    - if bitcount==DATA_WIDTH-1 -> stop, else bitcount++.
    - The 4-bit tick wraps 15->0 naturally.
    - Each sample falls mid-bit, 16 ticks after the previous sample.
  - stop: on baudTick, tick++. When tick==15 with baudTick, always return to idle, and:
    - if rxS==1 -> dataOut <= shift register, RxDone=1 for exactly the next clk;
    - if rxS==0 -> frameError=1 for exactly the next clk; dataOut is unchanged.
- Latency: RxDone/frameError are registered. Each rises on the clk edge after the stop-sample edge and lasts 1 clk.
- dataOut holds its value until the next valid frame.
- A new start edge is accepted in the cycle immediately after returning to idle. Back-to-back frames are supported with no gap beyond the stop bit.
- baudTick=0 forever: the FSM stalls in its current state; in idle it may still move to start on an edge.
- RxBusy = (state != idle), combinational from the state register.

Test Plan:
- Reset: assert rstN=0 mid-data-bit -> all outputs 0, state idle; after release, an rx=1 line produces no pulses.
- Single frame, baudTick every 4 clk, send 8'hA5 -> dataOut=8'hA5, exactly one RxDone pulse, frameError stays 0, RxBusy low afterwards.
- Back-to-back frames 8'h00, 8'hFF, 8'h3C with no idle gap -> three RxDone pulses; dataOut=00, FF, 3C in order.
- Glitch: rx low for 3 baudTicks then high -> no RxDone, no frameError; RxBusy returns to 0; next frame 8'h5A is received correctly.
- Framing error: send 8'h81 with stop bit 0, then hold rx low for 40 baudTicks -> one frameError pulse, dataOut keeps its previous value, and no second start while rx stays low.
- Loopback with the transmitter, DATA_WIDTH=8, 256 random words -> every word received equals the word sent, zero frameError.
